// File: rtl/instr_decode_ctrl.sv
// rtl/instr_decode_ctrl.sv - 16-bit instruction decoder/sequencer driving the ALU/regfile/flags control bundle.
// Optional DECODE_IMM_SIGN_EN: sign-extend short imm5 instead of zero-extending it.
module instr_decode_ctrl #(
    parameter int COUNT_W         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [15:0]        instr,
    output logic [15:0]        reg_en,
    output logic [3:0]         reg_a,
    output logic [3:0]         reg_b,
    output logic [15:0]        imm,
    output logic [1:0]         b_sel,
    output logic [3:0]         opcode,
    output logic               flag_en,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_IDLE, S_IMM, S_EXEC, S_HALT} state_t;

    state_t               state_q, state_d;
    logic [15:0]          reg_en_q, reg_en_d;
    logic [3:0]           reg_a_q, reg_a_d;
    logic [3:0]           reg_b_q, reg_b_d;
    logic [15:0]          imm_q, imm_d;
    logic [1:0]           b_sel_q, b_sel_d;
    logic [3:0]           opcode_q, opcode_d;
    logic                 flag_en_q, flag_en_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic [7:0]           pend_q, pend_d;
    logic [15:0]          short_imm;

`ifdef DECODE_IMM_SIGN_EN
    assign short_imm = {{11{instr[4]}}, instr[4:0]};
`else
    assign short_imm = {11'd0, instr[4:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            reg_en_q  <= '0;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            imm_q     <= '0;
            b_sel_q   <= '0;
            opcode_q  <= '0;
            flag_en_q <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            reg_en_q  <= reg_en_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            imm_q     <= imm_d;
            b_sel_q   <= b_sel_d;
            opcode_q  <= opcode_d;
            flag_en_q <= flag_en_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            pend_q    <= pend_d;
        end
    end

    // Control fields are loaded on the edge entering EXEC; enables self-clear on the way out.
    always_comb begin
        state_d   = state_q;
        reg_en_d  = '0;
        flag_en_d = 1'b0;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        imm_d     = imm_q;
        b_sel_d   = b_sel_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        pend_d    = pend_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    pend_d = instr[13:6];
                    case (instr[15:14])
                        2'b00: begin
                            opcode_d  = instr[13:10];
                            reg_a_d   = instr[9:6];
                            reg_b_d   = instr[5:2];
                            b_sel_d   = 2'd0;
                            reg_en_d  = instr[1] ? 16'h0000 : (16'h0001 << instr[9:6]);
                            flag_en_d = instr[0];
                            state_d   = S_EXEC;
                        end
                        2'b01: begin
                            if (instr[5]) begin
                                state_d = S_IMM;
                            end else begin
                                opcode_d  = instr[13:10];
                                reg_a_d   = instr[9:6];
                                reg_b_d   = 4'd0;
                                b_sel_d   = 2'd1;
                                imm_d     = short_imm;
                                reg_en_d  = 16'h0001 << instr[9:6];
                                flag_en_d = 1'b1;
                                state_d   = S_EXEC;
                            end
                        end
                        2'b10: begin
                            opcode_d  = instr[13:10];
                            reg_a_d   = instr[9:6];
                            reg_b_d   = 4'd0;
                            b_sel_d   = 2'd2;
                            reg_en_d  = 16'h0001 << instr[9:6];
                            state_d   = S_EXEC;
                        end
                        default: begin
                            if (instr[13:10] == 4'd1) begin
                                state_d = S_HALT;
                            end else if (instr[13:10] != 4'd0) begin
                                illegal_d = 1'b1;
                                if (HALT_ON_ILLEGAL) state_d = S_HALT;
                            end
                        end
                    endcase
                end
            end
            S_IMM: begin
                if (instr_valid) begin
                    opcode_d  = pend_q[7:4];
                    reg_a_d   = pend_q[3:0];
                    reg_b_d   = 4'd0;
                    b_sel_d   = 2'd1;
                    imm_d     = instr;
                    reg_en_d  = 16'h0001 << pend_q[3:0];
                    flag_en_d = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retired_q != {COUNT_W{1'b1}}) retired_d = retired_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign instr_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_IMM));
    assign busy        = (state_q != S_IDLE);
    assign halted      = (state_q == S_HALT);
    assign reg_en      = reg_en_q;
    assign reg_a       = reg_a_q;
    assign reg_b       = reg_b_q;
    assign imm         = imm_q;
    assign b_sel       = b_sel_q;
    assign opcode      = opcode_q;
    assign flag_en     = flag_en_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb/tb_instr_decode_ctrl.sv - directed self-checking bench for instr_decode_ctrl.
module tb_instr_decode_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [15:0]   reg_en;
    logic [3:0]    reg_a;
    logic [3:0]    reg_b;
    logic [15:0]   imm;
    logic [1:0]    b_sel;
    logic [3:0]    opcode;
    logic          flag_en;
    logic          busy;
    logic          halted;
    logic          illegal;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    instr_decode_ctrl #(.COUNT_W(CW), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .reg_en(reg_en), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
        .b_sel(b_sel), .opcode(opcode), .flag_en(flag_en), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word, wait (bounded) for ready, let it be accepted, then drop valid.
    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 8) begin
            step();
            n++;
        end
        chk("send_ready", instr_ready, 1);
        step();
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        step();
        step();
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retired", retired, 0);
        chk("rst_reg_en", reg_en, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", instr_ready, 1);

        send(16'h14D1);
        chk("r_opcode", opcode, 5);
        chk("r_reg_a", reg_a, 3);
        chk("r_reg_b", reg_b, 4);
        chk("r_b_sel", b_sel, 0);
        chk("r_reg_en", reg_en, 16'h0008);
        chk("r_flag_en", flag_en, 1);
        chk("r_ready_exec", instr_ready, 0);
        step();
        chk("r_retired", retired, 1);
        chk("r_reg_en_off", reg_en, 0);
        chk("r_opcode_hold", opcode, 5);

        send(16'h549F);
        chk("i_b_sel", b_sel, 1);
        chk("i_reg_en", reg_en, 16'h0004);
        chk("i_flag_en", flag_en, 1);
`ifdef DECODE_IMM_SIGN_EN
        chk("i_imm", imm, 16'hFFFF);
`else
        chk("i_imm", imm, 16'h001F);
`endif
        step();

        send(16'h54A0);
        chk("l_imm_ready", instr_ready, 1);
        chk("l_imm_reg_en", reg_en, 0);
        step();
        step();
        step();
        chk("l_imm_ready3", instr_ready, 1);
        chk("l_imm_busy", busy, 1);
        send(16'hBEEF);
        chk("l_imm", imm, 16'hBEEF);
        chk("l_reg_en", reg_en, 16'h0004);
        chk("l_flag_en", flag_en, 1);
        step();
        chk("l_retired", retired, 3);

        send(16'h81C0);
        chk("f_b_sel", b_sel, 2);
        chk("f_reg_a", reg_a, 7);
        chk("f_reg_en", reg_en, 16'h0080);
        chk("f_flag_en", flag_en, 0);
        step();
        chk("f_retired", retired, 4);

        for (int k = 0; k < 4; k++) begin
            send(16'h14D1);
            step();
        end
        chk("sat_retired", retired, 7);

        send(16'h54A0);
        chk("mid_imm_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_retired", retired, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", instr_ready, 0);
        chk("arst_ctrl", {imm, opcode, reg_a, reg_b, b_sel, flag_en}, 0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_rel_ready", instr_ready, 1);
        send(16'h14D1);
        chk("post_rst_reg_en", reg_en, 16'h0008);
        chk("post_rst_opcode", opcode, 5);
        step();
        chk("post_rst_retired", retired, 1);

        do_reset();
        send(16'h14D1);
        send(16'hC000);
        chk("s_nop_retired", retired, 1);
        chk("s_nop_busy", busy, 0);
        send(16'hC800);
        chk("s_illegal", illegal, 1);
        chk("s_ill_halted", halted, 0);
        send(16'hC400);
        instr       = 16'h14D1;
        instr_valid = 1'b1;
        step();
        step();
        step();
        chk("s_ready", instr_ready, 0);
        chk("s_halted", halted, 1);
        chk("s_retired", retired, 1);
        chk("s_illegal_sticky", illegal, 1);
        chk("s_reg_en", reg_en, 0);
        instr_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Control-side front end for the ALU/regfile/flags datapath.
- Accepts encoded 16-bit instruction words over a valid/ready stream and decodes them.
- Drives the datapath control bundle (reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en) for exactly one execute cycle per instruction.
- Replaces the hard-wired test sequencers with a program-driven controller.

Parameters:
- COUNT_W, 16: width of the retired-instruction counter; the counter saturates at all-ones.
- HALT_ON_ILLEGAL, 0: 1 = an illegal word enters HALT; 0 = it is treated as a NOP.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  decoder accepts a word this cycle
- instr  in  16  instruction or immediate-extension word
- reg_en  out  16  one-hot regfile write enable
- reg_a  out  4  regfile read port A / destination
- reg_b  out  4  regfile read port B
- imm  out  16  immediate to the B mux
- b_sel  out  2  B mux select: 0 = reg, 1 = imm, 2 = flags
- opcode  out  4  ALU opcode
- flag_en  out  1  flags register load
- busy  out  1  high when the FSM is not in IDLE
- halted  out  1  HALT state
- illegal  out  1  sticky illegal-encoding flag
- retired  out  COUNT_W  instructions executed

Behaviour:
- Word format:
  - [15:14] fmt: 00 R, 01 I, 10 flags-read, 11 system.
  - [13:10] ALU opcode.
  - [9:6] rdest.
- R-type: [5:2] rsrc; [1] nowb (1 = no write-back, compare-style); [0] fl (update flags).
- I-type: [5] long; [4:0] imm5.
  - long = 1: the next accepted word is the full 16-bit immediate.
  - I-type always writes rdest and sets flag_en = 1.
- flags-read: writes rdest with opcode [13:10] and b_sel = 2; no flag update.
- System: [13:10] 0000 = NOP, 0001 = HALT, anything else = illegal.
- States: IDLE, IMM, EXEC, HALT.
- IDLE:
  - instr_ready = 1. On valid & ready, latch the word.
  - Long I-type goes to IMM. System NOP/illegal stays in IDLE. HALT goes to HALT. Everything else goes to EXEC.
- IMM:
  - instr_ready = 1; wait for valid. The accepted word becomes imm, then go to EXEC.
- EXEC:
  - Lasts one cycle; instr_ready = 0. Control outputs are registered and valid during this cycle only.
  - reg_a = rdest. reg_b = rsrc (R-type) or 0.
  - reg_en = 1 << rdest unless R-type with nowb = 1 (then 0).
  - flag_en per format.
  - retired increments at the end of the cycle; return to IDLE.
- Outside EXEC:
  - reg_en = 0 and flag_en = 0.
  - reg_a, reg_b, imm, b_sel and opcode hold their last values.
- Throughput:
  - 2 cycles per instruction (accept + exec); 3 cycles for long I-type.
  - Back-to-back valid is allowed; there is no bubble beyond EXEC.
- NOP: consumes the word and does not increment retired.
- Illegal:
  - Sets illegal (sticky until reset); does not retire.
  - Goes to HALT if HALT_ON_ILLEGAL = 1.
- HALT: instr_ready = 0 and halted = 1 until reset. retired does not count the HALT word.
- Reset (any time, including mid-IMM or mid-EXEC):
  - State goes to IDLE immediately.
  - All outputs go to 0, except instr_ready, which is 1 once reset deasserts.
  - A partially received long I-type is discarded.
- retired saturates at 2^COUNT_W - 1.

Optional Feature:
- Macro: DECODE_IMM_SIGN_EN.
- Defined: short imm5 is sign-extended to 16 bits.
- Undefined: short imm5 is zero-extended.
- Long immediates are unaffected either way.

Test Plan:
- R-type 0x14D1 → EXEC cycle shows opcode = 5, reg_a = 3, reg_b = 4, b_sel = 0, reg_en = 0x0008, flag_en = 1; retired = 1.
- Short I-type 0x549F → b_sel = 1, reg_en = 0x0004, flag_en = 1; imm = 0xFFFF with DECODE_IMM_SIGN_EN, 0x001F without.
- Long I-type 0x54A0, then 0xBEEF after 3 idle cycles:
  - instr_ready stays high in IMM.
  - EXEC shows imm = 0xBEEF and reg_en = 0x0004.
- Flags-read 0x81C0 → b_sel = 2, reg_a = 7, reg_en = 0x0080, flag_en = 0.
- Stream 0x14D1, 0xC000 (NOP), 0xC800 (illegal), 0xC400 (HALT), 0x14D1:
  - retired = 1, illegal = 1, halted = 1.
  - The final word is never accepted (instr_ready = 0).
- rst asserted during IMM after 0x54A0:
  - All outputs clear asynchronously and retired = 0.
  - After release, 0x14D1 executes normally.
